// File: rtl/nios_system_onchip_memory2_dp.sv
`default_nettype none
// ============================================================================
// Module   : nios_system_onchip_memory2_dp
// Brief    : True dual-port on-chip RAM with byte enables, clock enable and a
//            1- or 2-cycle read pipeline per port (port A wins write collisions).
// Revision : 1.0
// ============================================================================
module nios_system_onchip_memory2_dp #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = "nios_system_onchip_memory2_dp.hex"
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic                    a_chipselect,
  input  logic                    a_read,
  input  logic                    a_write,
  input  logic [DATA_WIDTH/8-1:0] a_byteenable,
  input  logic [DATA_WIDTH-1:0]   a_writedata,
  output logic [DATA_WIDTH-1:0]   a_readdata,
  output logic                    a_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   b_address,
  input  logic                    b_chipselect,
  input  logic                    b_read,
  input  logic                    b_write,
  input  logic [DATA_WIDTH/8-1:0] b_byteenable,
  input  logic [DATA_WIDTH-1:0]   b_writedata,
  output logic [DATA_WIDTH-1:0]   b_readdata,
  output logic                    b_readdatavalid
);

  localparam int                c_NB    = DATA_WIDTH / 8;
  localparam int                c_IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

  // Power-up contents come from the device configuration flow; only the name is carried here.
  logic w_unused_init;
  assign w_unused_init = ^INIT_FILE;

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  logic            w_a_inr, w_b_inr;
  logic            w_a_rd, w_b_rd;
  logic            w_a_wr, w_b_wr;
  logic [c_IW-1:0] w_a_idx, w_b_idx;

  assign w_a_inr = ({1'b0, a_address} < c_DEPTH);
  assign w_b_inr = ({1'b0, b_address} < c_DEPTH);
  assign w_a_idx = a_address[c_IW-1:0];
  assign w_b_idx = b_address[c_IW-1:0];
  assign w_a_rd  = clken & a_chipselect & a_read;
  assign w_b_rd  = clken & b_chipselect & b_read;
  assign w_a_wr  = clken & a_chipselect & a_write & w_a_inr;
  assign w_b_wr  = clken & b_chipselect & b_write & w_b_inr;

  // Port A lanes are scheduled after port B so A wins on shared lanes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < c_NB; i++) begin
      if (w_b_wr && b_byteenable[i]) r_mem[w_b_idx][i*8 +: 8] <= b_writedata[i*8 +: 8];
      if (w_a_wr && a_byteenable[i]) r_mem[w_a_idx][i*8 +: 8] <= a_writedata[i*8 +: 8];
    end
  end

  logic                  r_a_v1, r_b_v1;
  logic [DATA_WIDTH-1:0] r_a_d1, r_b_d1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_v1 <= 1'b0;
      r_a_d1 <= '0;
      r_b_v1 <= 1'b0;
      r_b_d1 <= '0;
    end else if (clken) begin
      r_a_v1 <= w_a_rd;
      r_b_v1 <= w_b_rd;
      if (w_a_rd) r_a_d1 <= w_a_inr ? r_mem[w_a_idx] : '0;
      if (w_b_rd) r_b_d1 <= w_b_inr ? r_mem[w_b_idx] : '0;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  r_a_v2, r_b_v2;
      logic [DATA_WIDTH-1:0] r_a_d2, r_b_d2;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_a_v2 <= 1'b0;
          r_a_d2 <= '0;
          r_b_v2 <= 1'b0;
          r_b_d2 <= '0;
        end else if (clken) begin
          r_a_v2 <= r_a_v1;
          r_a_d2 <= r_a_d1;
          r_b_v2 <= r_b_v1;
          r_b_d2 <= r_b_d1;
        end
      end

      assign a_readdata      = r_a_d2;
      assign a_readdatavalid = r_a_v2;
      assign b_readdata      = r_b_d2;
      assign b_readdatavalid = r_b_v2;
    end else begin : g_lat1
      assign a_readdata      = r_a_d1;
      assign a_readdatavalid = r_a_v1;
      assign b_readdata      = r_b_d1;
      assign b_readdatavalid = r_b_v1;
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/nios_system_onchip_memory2_dp.md
NIOS_SYSTEM_ONCHIP_MEMORY2_DP -- requirements
Module: nios_system_onchip_memory2_dp

Interface
REQ-001 Parameter DATA_WIDTH, 32, data bits per word; multiple of 8.
REQ-002 Parameter ADDR_WIDTH, 10, word-address bits.
REQ-003 Parameter DEPTH, 1024, words implemented; DEPTH <= 2**ADDR_WIDTH.
REQ-004 Parameter READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values 1 or 2.
REQ-005 Parameter INIT_FILE, "nios_system_onchip_memory2_dp.hex", power-up contents.
REQ-006 clk  in  1  single clock; all ports synchronous to its rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 clken  in  1  global clock enable; low = full stall.
REQ-009 a_address  in  ADDR_WIDTH  port A word address.
REQ-010 a_chipselect  in  1  port A select.
REQ-011 a_read  in  1  port A read request.
REQ-012 a_write  in  1  port A write request.
REQ-013 a_byteenable  in  DATA_WIDTH/8  port A write lane mask.
REQ-014 a_writedata  in  DATA_WIDTH  port A write data.
REQ-015 a_readdata  out  DATA_WIDTH  port A read data.
REQ-016 a_readdatavalid  out  1  port A read data qualifier.
REQ-017 b_address, b_chipselect, b_read, b_write, b_byteenable, b_writedata, b_readdata and b_readdatavalid SHALL mirror REQ-009..016 for port B.

Function
REQ-018 An access on a port is accepted in a cycle with clken=1 and chipselect=1; otherwise read and write are ignored.
REQ-019 An accepted write updates only the byte lanes whose byteenable bit is 1; all other lanes are unchanged.
REQ-020 An accepted read SHALL assert readdatavalid exactly READ_LATENCY cycles later (counting clken=1 cycles only), for one cycle, with readdata valid in that cycle.
REQ-021 READ_LATENCY=2 SHALL add an output register stage; back-to-back reads SHALL sustain one result per cycle on each port.
REQ-022 Read and write asserted together on one port: the write is performed, and the read returns the old (pre-write) data.
REQ-023 A read on one port to an address written in the same cycle by the other port returns the old data.
REQ-024 Both ports writing the same address in the same cycle: port A wins on every lane enabled on both ports; lanes enabled only on port B take port B data.
REQ-025 An address >= DEPTH is ignored for writes, and returns all-zero data on reads, with readdatavalid still asserted.
REQ-026 When clken=0, the memory, the pipeline registers, readdata and readdatavalid SHALL hold their values; no pending read is lost.
REQ-027 Ports A and B SHALL be fully independent apart from REQ-023/024; no waitrequest, and no stalls.

Reset
REQ-028 reset_n=0 SHALL asynchronously clear a_readdatavalid, b_readdatavalid, a_readdata, b_readdata and all read pipeline stages to 0.
REQ-029 Reset SHALL NOT alter memory contents; INIT_FILE contents apply only at configuration.
REQ-030 Reads in flight when reset asserts SHALL be discarded; no readdatavalid may follow reset release for a read accepted before reset.
REQ-031 Accesses in the first clk edge after reset_n deasserts SHALL be accepted normally.

Verification
REQ-032 Byte-enable test: A writes 0x11223344 to addr 5 with be=1111, then 0xAABBCCDD with be=0101; B reads addr 5 -> 0x11BB33DD, valid after READ_LATENCY cycles.
REQ-033 Collision test: A writes 0xFFFFFFFF with be=0011 and B writes 0x00000000 with be=1111, same cycle, addr 7 (previously 0x12345678); read -> 0x0000FFFF.
REQ-034 Read-during-write test: addr 3 = 0x1; A writes 0x2 while B reads addr 3 -> B gets 0x1; the next read gets 0x2.
REQ-035 Stall test, READ_LATENCY=2: read issued, clken dropped for 3 cycles after acceptance -> valid appears on the 2nd clken=1 cycle, exactly once.
REQ-036 Reset test: reset_n pulsed low one cycle after a read is accepted -> readdatavalid stays 0 throughout; the memory word is unchanged on re-read.
REQ-037 Out-of-range test: DEPTH=1000, ADDR_WIDTH=10, write to addr 1020 then read -> 0x00000000 with valid asserted; addr 1020 mod 1000 unchanged.
